// File: rtl/mem_gearbox_pkg.sv
// mem_gearbox_pkg: shared mode encodings and ratio/width helpers for mem_gearbox
// DATA_WIDTH is the global element width; the default below only applies when nothing defines it.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package mem_gearbox_pkg;

    typedef enum logic [1:0] {
        MODE_PASS,
        MODE_PACK,
        MODE_UNPACK
    } mode_e;

    function automatic int gb_ratio(int in_w, int out_w);
        return in_w > out_w ? in_w / out_w : out_w / in_w;
    endfunction

    function automatic bit gb_valid(int in_w, int out_w);
        return in_w > 0 && out_w > 0 && (in_w > out_w ? in_w % out_w : out_w % in_w) == 0;
    endfunction

    function automatic mode_e gb_mode(int in_w, int out_w);
        return in_w == out_w ? MODE_PASS : (in_w < out_w ? MODE_PACK : MODE_UNPACK);
    endfunction

    // Counter width that stays legal for RATIO == 1.
    function automatic int gb_cnt_w(int ratio);
        return ratio > 1 ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/mem_gearbox_slot_ctr.sv
// mem_gearbox_slot_ctr: modulo-RATIO slot counter shared by the pack and unpack datapaths
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   inc_i      advance one slot, wrapping to 0 after RATIO-1
//   clr_i      force the count back to slot 0
//   cnt_o      current slot index
//   wrap_o     high while the count sits on the final slot
module mem_gearbox_slot_ctr
    import mem_gearbox_pkg::*;
#(
    parameter int RATIO = 8,
    localparam int CW   = gb_cnt_w(RATIO)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          wrap_o
);

    assign wrap_o = cnt_o == CW'(RATIO - 1);

    always_ff @(posedge clk) begin
        if (rst || clr_i || (inc_i && wrap_o))
            cnt_o <= '0;
        else if (inc_i)
            cnt_o <= cnt_o + 1'b1;
    end

endmodule

// File: rtl/mem_gearbox.sv
// mem_gearbox: sequential element-width gearbox between two valid/ready vector buses
// Ports:
//   clk, rst                                        clock, synchronous active-high reset
//   in_valid_i/in_ready_o/in_data_i/in_last_i       input beat of IN_WIDTH elements
//   out_valid_o/out_ready_i/out_data_o/out_last_o   output beat of OUT_WIDTH elements
//   out_keep_o                                      per-element fill mask, only with MEM_GEARBOX_KEEP_EN
// IN_WIDTH < OUT_WIDTH packs, IN_WIDTH > OUT_WIDTH unpacks, equal widths give one register stage.
module mem_gearbox
    import mem_gearbox_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid_i,
    output logic                             in_ready_o,
    input  logic [`DATA_WIDTH*IN_WIDTH-1:0]  in_data_i,
    input  logic                             in_last_i,
    output logic                             out_valid_o,
    input  logic                             out_ready_i,
    output logic [`DATA_WIDTH*OUT_WIDTH-1:0] out_data_o,
    output logic                             out_last_o
`ifdef MEM_GEARBOX_KEEP_EN
    ,
    output logic [OUT_WIDTH-1:0]             out_keep_o
`endif
);

    localparam int    DW    = `DATA_WIDTH;
    localparam int    IW    = DW * IN_WIDTH;
    localparam int    OW    = DW * OUT_WIDTH;
    localparam int    RATIO = gb_ratio(IN_WIDTH, OUT_WIDTH);
    localparam int    CW    = gb_cnt_w(RATIO);
    localparam mode_e MODE  = gb_mode(IN_WIDTH, OUT_WIDTH);

    if (!gb_valid(IN_WIDTH, OUT_WIDTH)) begin : g_bad_ratio
        $error("mem_gearbox: IN_WIDTH and OUT_WIDTH must be integer multiples of each other");
    end

    logic [CW-1:0] cnt;
    logic          wrap;
    logic          inc;
    logic          clr;
    logic          in_fire;
    logic          out_fire;

    assign in_fire  = in_valid_i && in_ready_o;
    assign out_fire = out_valid_o && out_ready_i;

    mem_gearbox_slot_ctr #(.RATIO(RATIO)) u_slot_ctr (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (inc),
        .clr_i  (clr),
        .cnt_o  (cnt),
        .wrap_o (wrap)
    );

    if (MODE == MODE_UNPACK) begin : g_unpack
        logic [IW-1:0] hold_q;
        logic          last_q;
        // A refill is allowed while the final slice hands off, so consecutive beats stream without bubbles.
        assign in_ready_o = !rst && (!out_valid_o || (out_ready_i && wrap));
        assign inc        = out_fire;
        assign clr        = 1'b0;
        assign out_data_o = hold_q[cnt*OW +: OW];
        assign out_last_o = last_q && wrap;
        always_ff @(posedge clk) begin
            if (rst) begin
                hold_q      <= '0;
                last_q      <= 1'b0;
                out_valid_o <= 1'b0;
`ifdef MEM_GEARBOX_KEEP_EN
                out_keep_o  <= '0;
`endif
            end else if (in_fire) begin
                hold_q      <= in_data_i;
                last_q      <= in_last_i;
                out_valid_o <= 1'b1;
`ifdef MEM_GEARBOX_KEEP_EN
                out_keep_o  <= '1;
`endif
            end else if (out_fire && wrap) begin
                out_valid_o <= 1'b0;
            end
        end
    end else begin : g_pack
        logic [OW-1:0] acc_q;
        logic [OW-1:0] acc_d;
        logic [OW-1:0] beat;
        logic          done;
        // Equal widths fall through here with RATIO == 1: every beat completes immediately.
        assign in_ready_o = !rst && (!out_valid_o || out_ready_i);
        assign done       = wrap || in_last_i;
        assign inc        = in_fire && !done;
        assign clr        = in_fire && done;
        always_comb begin
            beat          = '0;
            beat[IW-1:0]  = in_data_i;
        end
        // Slots above cnt are still zero in the accumulator, which provides the zero padding on early last.
        assign acc_d = acc_q | (beat << (cnt * IW));
        always_ff @(posedge clk) begin
            if (rst) begin
                acc_q       <= '0;
                out_valid_o <= 1'b0;
                out_data_o  <= '0;
                out_last_o  <= 1'b0;
`ifdef MEM_GEARBOX_KEEP_EN
                out_keep_o  <= '0;
`endif
            end else begin
                if (out_fire)
                    out_valid_o <= 1'b0;
                if (in_fire && done) begin
                    acc_q       <= '0;
                    out_valid_o <= 1'b1;
                    out_data_o  <= acc_d;
                    out_last_o  <= in_last_i;
`ifdef MEM_GEARBOX_KEEP_EN
                    out_keep_o  <= ~({OUT_WIDTH{1'b1}} << ((cnt + 1) * IN_WIDTH));
`endif
                end else if (in_fire) begin
                    acc_q <= acc_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_gearbox.sv
// tb_mem_gearbox: scoreboard bench for pack (32->256), unpack (256->32) and equal (32->32) gearboxes
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tb_mem_gearbox;

    localparam int DW = `DATA_WIDTH;
    localparam int MW = DW * 256;
    localparam int PI = 32, PO = 256, UI = 256, UO = 32, EW = 32;

    typedef struct {
        logic [MW-1:0]  d;
        logic           l;
        logic [255:0]   k;
        int             t;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic             p_iv, p_ir, p_il, p_ov, p_or, p_ol;
    logic [DW*PI-1:0] p_id;
    logic [DW*PO-1:0] p_od;
    logic             u_iv, u_ir, u_il, u_ov, u_or, u_ol;
    logic [DW*UI-1:0] u_id;
    logic [DW*UO-1:0] u_od;
    logic             e_iv, e_ir, e_il, e_ov, e_or, e_ol;
    logic [DW*EW-1:0] e_id;
    logic [DW*EW-1:0] e_od;
`ifdef MEM_GEARBOX_KEEP_EN
    logic [PO-1:0] p_ok;
    logic [UO-1:0] u_ok;
    logic [EW-1:0] e_ok;
`endif

    mem_gearbox #(.IN_WIDTH(PI), .OUT_WIDTH(PO)) u_pack (
        .clk(clk), .rst(rst), .in_valid_i(p_iv), .in_ready_o(p_ir), .in_data_i(p_id), .in_last_i(p_il),
        .out_valid_o(p_ov), .out_ready_i(p_or), .out_data_o(p_od), .out_last_o(p_ol)
`ifdef MEM_GEARBOX_KEEP_EN
        , .out_keep_o(p_ok)
`endif
    );

    mem_gearbox #(.IN_WIDTH(UI), .OUT_WIDTH(UO)) u_unpack (
        .clk(clk), .rst(rst), .in_valid_i(u_iv), .in_ready_o(u_ir), .in_data_i(u_id), .in_last_i(u_il),
        .out_valid_o(u_ov), .out_ready_i(u_or), .out_data_o(u_od), .out_last_o(u_ol)
`ifdef MEM_GEARBOX_KEEP_EN
        , .out_keep_o(u_ok)
`endif
    );

    mem_gearbox #(.IN_WIDTH(EW), .OUT_WIDTH(EW)) u_equal (
        .clk(clk), .rst(rst), .in_valid_i(e_iv), .in_ready_o(e_ir), .in_data_i(e_id), .in_last_i(e_il),
        .out_valid_o(e_ov), .out_ready_i(e_or), .out_data_o(e_od), .out_last_o(e_ol)
`ifdef MEM_GEARBOX_KEEP_EN
        , .out_keep_o(e_ok)
`endif
    );

    exp_t           sb[3][$];
    logic [DW-1:0]  pend[3][$];
    int             rmode[3];
    logic           tog[3];
    logic           stall[3];
    logic [MW-1:0]  hd[3];
    logic           hl[3];
    int             hs_n[3], hs_first[3], hs_last[3];

    function automatic int inw(int d);
        return d == 0 ? PI : d == 1 ? UI : EW;
    endfunction

    function automatic int outw(int d);
        return d == 0 ? PO : d == 1 ? UO : EW;
    endfunction

    function automatic logic [MW-1:0] rnd_vec();
        logic [MW-1:0] v;
        for (int i = 0; i < MW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(string nm, longint a, longint e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    task automatic chk_vec(string nm, logic [MW-1:0] a, logic [MW-1:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            for (int i = 0; i < 256; i++)
                if (a[i*DW +: DW] !== e[i*DW +: DW]) begin
                    $display("FAIL %s elem %0d: got %h expected %h", nm, i, a[i*DW +: DW], e[i*DW +: DW]);
                    break;
                end
        end
    endtask

    task automatic set_in(int d, logic v, logic [MW-1:0] data, logic last);
        case (d)
            0: begin p_iv = v; p_id = data[DW*PI-1:0]; p_il = last; end
            1: begin u_iv = v; u_id = data[DW*UI-1:0]; u_il = last; end
            default: begin e_iv = v; e_id = data[DW*EW-1:0]; e_il = last; end
        endcase
    endtask

    task automatic set_or(int d, logic r);
        case (d)
            0: p_or = r;
            1: u_or = r;
            default: e_or = r;
        endcase
    endtask

    task automatic sample(int d, output logic ov, output logic orr, output logic ir, output logic ol,
                          output logic [MW-1:0] od, output logic [255:0] ok);
        od = '0;
        ok = '0;
        case (d)
            0: begin ov = p_ov; orr = p_or; ir = p_ir; ol = p_ol; od[DW*PO-1:0] = p_od;
`ifdef MEM_GEARBOX_KEEP_EN
                ok[PO-1:0] = p_ok;
`endif
            end
            1: begin ov = u_ov; orr = u_or; ir = u_ir; ol = u_ol; od[DW*UO-1:0] = u_od;
`ifdef MEM_GEARBOX_KEEP_EN
                ok[UO-1:0] = u_ok;
`endif
            end
            default: begin ov = e_ov; orr = e_or; ir = e_ir; ol = e_ol; od[DW*EW-1:0] = e_od;
`ifdef MEM_GEARBOX_KEEP_EN
                ok[EW-1:0] = e_ok;
`endif
            end
        endcase
    endtask

    // Reference: an element stream regrouped into OUT-element beats; last flushes a zero-padded remainder.
    task automatic model(int d, logic [MW-1:0] data, logic last, int t);
        exp_t e;
        int   first = t;
        for (int i = 0; i < inw(d); i++) pend[d].push_back(data[i*DW +: DW]);
        while (pend[d].size() >= outw(d) || (last && pend[d].size() > 0)) begin
            e.d = '0;
            e.k = '0;
            e.t = first;
            first = -1;
            for (int i = 0; i < outw(d) && pend[d].size() > 0; i++) begin
                e.d[i*DW +: DW] = pend[d].pop_front();
                e.k[i] = 1'b1;
            end
            e.l = last && pend[d].size() == 0;
            sb[d].push_back(e);
        end
    endtask

    task automatic send(int d, logic [MW-1:0] data, logic last);
        logic ov, orr, ir, ol;
        logic [MW-1:0] od;
        logic [255:0] ok;
        @(negedge clk);
        set_in(d, 1'b1, data, last);
        for (int n = 0; n < 500; n++) begin
            #1;
            sample(d, ov, orr, ir, ol, od, ok);
            if (ir) begin
                model(d, data, last, cyc);
                @(posedge clk);
                return;
            end
            @(negedge clk);
        end
        tests++;
        fails++;
        $display("FAIL send d%0d: in_ready stayed low", d);
    endtask

    task automatic idle(int d);
        @(negedge clk);
        set_in(d, 1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && (sb[0].size() + sb[1].size() + sb[2].size()) > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) chk($sformatf("drain d%0d pending outputs", d), sb[d].size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            set_in(d, 1'b0, '0, 1'b0);
            pend[d].delete();
            sb[d].delete();
            stall[d] = 1'b0;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic mon(int d);
        logic ov, orr, ir, ol;
        logic [MW-1:0] od;
        logic [255:0] ok;
        exp_t e;
        sample(d, ov, orr, ir, ol, od, ok);
        if (d == 1) begin
            if (!ov) chk("unpack in_ready while empty", ir, 1);
            if (ov && !orr) chk("unpack in_ready while stalled", ir, 0);
        end else begin
            chk($sformatf("d%0d in_ready low only when stalled", d), ir, !ov || orr);
        end
        if (stall[d]) begin
            chk($sformatf("d%0d valid held while stalled", d), ov, 1);
            if (ov) begin
                chk_vec($sformatf("d%0d data held while stalled", d), od, hd[d]);
                chk($sformatf("d%0d last held while stalled", d), ol, hl[d]);
            end
        end
        if (ov && !stall[d] && sb[d].size() > 0 && sb[d][0].t >= 0)
            chk($sformatf("d%0d latency cycle", d), cyc, sb[d][0].t + 1);
        if (ov && orr) begin
            hs_n[d]++;
            if (hs_n[d] == 1) hs_first[d] = cyc;
            hs_last[d] = cyc;
            if (sb[d].size() == 0) begin
                tests++;
                fails++;
                $display("FAIL d%0d unexpected output beat", d);
            end else begin
                e = sb[d].pop_front();
                chk_vec($sformatf("d%0d out_data", d), od, e.d);
                chk($sformatf("d%0d out_last", d), ol, e.l);
`ifdef MEM_GEARBOX_KEEP_EN
                tests++;
                if (ok !== e.k) begin
                    fails++;
                    $display("FAIL d%0d out_keep: got %0d ones expected %0d ones", d, $countones(ok), $countones(e.k));
                end
`endif
            end
        end
        stall[d] = ov && !orr;
        hd[d] = od;
        hl[d] = ol;
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            tog[d] = ~tog[d];
            set_or(d, rmode[d] == 0 ? 1'b1 : rmode[d] == 1 ? tog[d] : 1'($urandom_range(1)));
        end
        #1;
        if (!rst) for (int d = 0; d < 3; d++) mon(d);
    end

    initial begin
        logic [MW-1:0] v;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            rmode[d] = 0;
            tog[d] = 1'b0;
            stall[d] = 1'b0;
            hs_n[d] = 0;
            set_in(d, 1'b0, '0, 1'b0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("reset pack in_ready", p_ir, 0);
        chk("reset unpack in_ready", u_ir, 0);
        chk("reset equal in_ready", e_ir, 0);
        chk("reset pack out_valid", p_ov, 0);
        chk("reset unpack out_valid", u_ov, 0);
        chk("reset equal out_valid", e_ov, 0);
        chk("reset pack out_last", p_ol, 0);
        chk("reset unpack out_last", u_ol, 0);
        chk("reset equal out_last", e_ol, 0);
        chk("reset pack out_data zero", p_od == '0, 1);
        chk("reset unpack out_data zero", u_od == '0, 1);
        chk("reset equal out_data zero", e_od == '0, 1);
`ifdef MEM_GEARBOX_KEEP_EN
        chk("reset pack out_keep zero", p_ok == '0, 1);
`endif
        rst = 1'b0;

        // Full pack with element g carrying value g.
        for (int b = 0; b < 8; b++) begin
            v = '0;
            for (int i = 0; i < PI; i++) v[i*DW +: DW] = DW'(b * PI + i);
            if (b == 7) begin
                idle(0);
                #2;
                chk("pack no output before beat 8", p_ov, 0);
            end
            send(0, v, b == 7);
        end
        idle(0);
        #2;
        chk("pack out_valid one cycle after beat 8", p_ov, 1);
        drain();

        // Early last on beat 3, then a full packet that must start at slot 0.
        for (int b = 0; b < 3; b++) send(0, rnd_vec(), b == 2);
        for (int b = 0; b < 8; b++) send(0, rnd_vec(), b == 7);
        idle(0);
        drain();

        // Two back-to-back unpack beats: 16 slices with no bubble.
        hs_n[1] = 0;
        send(1, rnd_vec(), 1'b0);
        send(1, rnd_vec(), 1'b1);
        idle(1);
        repeat (40) @(negedge clk);
        #2;
        chk("unpack slice count", hs_n[1], 16);
        chk("unpack no bubble span", hs_last[1] - hs_first[1], 15);
        drain();

        // Toggling backpressure in both modes.
        rmode[0] = 1;
        rmode[1] = 1;
        fork
            begin
                for (int b = 0; b < 24; b++) send(0, rnd_vec(), $urandom_range(4) == 0);
                idle(0);
            end
            begin
                for (int b = 0; b < 6; b++) send(1, rnd_vec(), $urandom_range(2) == 0);
                idle(1);
            end
        join
        drain();

        // Reset mid-packet: 5 beats discarded, next 8 form a clean output.
        rmode[0] = 0;
        rmode[1] = 0;
        for (int b = 0; b < 8; b++) send(0, '0, 1'b0);
        idle(0);
        drain();
        for (int b = 0; b < 5; b++) send(0, rnd_vec(), 1'b0);
        idle(0);
        do_reset();
        repeat (3) @(negedge clk);
        #2;
        chk("pack no output after mid-packet reset", p_ov, 0);
        for (int b = 0; b < 8; b++) send(0, rnd_vec(), b == 7);
        idle(0);
        drain();

        // Random valid/ready on all three, with random idle gaps.
        for (int d = 0; d < 3; d++) rmode[d] = 2;
        fork
            begin
                for (int b = 0; b < 60; b++) begin
                    send(2, rnd_vec(), $urandom_range(3) == 0);
                    if ($urandom_range(3) == 0) idle(2);
                end
                idle(2);
            end
            begin
                for (int b = 0; b < 24; b++) begin
                    send(0, rnd_vec(), $urandom_range(5) == 0);
                    if ($urandom_range(3) == 0) idle(0);
                end
                idle(0);
            end
            begin
                for (int b = 0; b < 5; b++) begin
                    send(1, rnd_vec(), $urandom_range(1) == 0);
                    if ($urandom_range(3) == 0) idle(1);
                end
                idle(1);
            end
        join
        for (int d = 0; d < 3; d++) rmode[d] = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_gearbox.md
Name: mem_gearbox

Overview:
- Sequential element-width converter between two vector buses of `DATA_WIDTH`-bit elements, each with a valid/ready handshake.
- Packs several narrow beats into one wide beat (IN_WIDTH < OUT_WIDTH), or unpacks one wide beat into several narrow beats (IN_WIDTH > OUT_WIDTH).
- Sits between memory-side vector buses and compute arrays wherever element counts differ and backpressure must be honoured.

Parameters:
- IN_WIDTH, 32, number of elements per input beat.
- OUT_WIDTH, 256, number of elements per output beat; one of IN_WIDTH and OUT_WIDTH must be an integer multiple of the other (elaboration error otherwise).
- RATIO (derived, not overridable): max(IN,OUT)/min(IN,OUT).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid&in_ready.
- in_data  in  `DATA_WIDTH*IN_WIDTH  element g at [`DATA_WIDTH*g +: `DATA_WIDTH].
- in_last  in  1  last beat of packet; flushes a partial pack.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  `DATA_WIDTH*OUT_WIDTH  same element packing as in_data.
- out_last  out  1  last output beat of packet.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, out_last=0, out_data=0, slot counter=0, accumulator/holding register=0. in_ready=0 combinationally while rst=1. Asserting reset mid-packet discards all partial data; no output is produced for it.
- Output stability: out_data/out_last held stable while out_valid & !out_ready. out_valid drops only after a handshake.
- Pack mode (IN<OUT):
  - cnt in 0..RATIO-1; an accepted beat is written to accumulator elements [cnt*IN_WIDTH +: IN_WIDTH], lowest slot first.
  - Completing beat (cnt==RATIO-1 or in_last=1): accumulator plus this beat, with unfilled slots forced to zero, is loaded into the output register. out_valid=1 the next cycle; out_last=in_last; cnt->0; accumulator cleared.
  - Otherwise cnt++.
  - in_ready = !rst & (!out_valid | out_ready), so a completing beat may coincide with an output handshake.
  - Latency: 1 cycle from completing beat to out_valid. Full throughput when out_ready=1 (one output per RATIO inputs).
  - in_last on the first beat (cnt=0): output carries IN_WIDTH elements, remainder zero.
- Unpack mode (IN>OUT):
  - Holding register plus full flag; idx in 0..RATIO-1.
  - out_data = hold[idx*OUT_WIDTH +: OUT_WIDTH]; out_valid = full.
  - On output handshake: idx++. At idx==RATIO-1, full clears and idx->0.
  - out_last = last_reg & (idx==RATIO-1).
  - in_ready = !rst & (!full | (out_ready & idx==RATIO-1)), so a back-to-back refill on the final slice gives zero bubbles.
  - Latency: 1 cycle from input accept to first slice.
- Equal mode (RATIO=1): single registered pipeline stage, in_ready = !out_valid | out_ready, latency 1.
- in_valid=0 with the output stalled: state holds indefinitely.

Optional Feature:
- Macro: MEM_GEARBOX_KEEP_EN.
- Defined: adds port out_keep (out, OUT_WIDTH bits), one bit per output element.
  - Pack: 1 for filled slots, 0 for zero-padded slots.
  - Unpack/equal: all ones.
  - Reset value 0; held stable with out_data.
- Undefined: port absent; zero-padding behaviour unchanged.

Decomposition:
- Shared package/header: `DATA_WIDTH (existing global), mode encodings (MODE_PACK, MODE_UNPACK, MODE_PASS), ratio/log2 constant helpers.
- One natural sub-module: mem_gearbox_slot_ctr.
  - Modulo-RATIO counter with inc, clr and wrap outputs.
  - Used in both modes, since pack and unpack differ only in datapath muxing.

Test Plan (DATA_WIDTH=8):
- Pack, IN=32/OUT=256, 8 beats, element value = global index 0..255, out_ready=1 -> one output, element g==g, out_last per last beat, out_valid 1 cycle after beat 8.
- Pack, in_last on beat 3 -> output elements 0..95 data, 96..255 zero, out_last=1, cnt restarts at 0; with MEM_GEARBOX_KEEP_EN, out_keep=96 ones then 160 zeros.
- Unpack, IN=256/OUT=32, two back-to-back beats, out_ready=1 -> 16 consecutive out_valid cycles with no bubble, slices in order, out_last only on slice 15 when second beat in_last=1.
- Backpressure: out_ready toggling 1010... in both modes -> out_data stable while stalled, no element loss or duplication (scoreboard), in_ready low only while output full and stalled.
- Reset mid-packet: rst after 5 of 8 pack beats -> no output, out_valid=0; the next 8 beats form a clean output with no stale elements.
- Equal mode IN=OUT=32, random valid/ready -> output stream identical to input stream, latency 1.
